// File: rtl/sev_seg_mux.sv
// Time-multiplexed common-anode hex display driver with guard time, PWM dimming,
// leading-zero blanking and frame-synchronous capture of the display data.
module sev_seg_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    lz_blank,
  input  logic [3:0]              bright,
  output logic [6:0]              sev_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              pwm;
  logic [4*NUM_DIGITS-1:0] sh_din;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;

  logic [NUM_DIGITS-1:0]   sup;
  logic                    zero_run;
  logic                    past_guard;
  logic                    lit;
  logic [3:0]              nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // A digit is blank when it and every more significant digit are zero; digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    sup      = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (sh_din[4*i +: 4] == 4'h0);
      sup[i]   = lz_blank && zero_run;
    end
  end

  generate
    if (GUARD == 0) begin : g_no_guard
      assign past_guard = 1'b1;
    end else begin : g_guard
      assign past_guard = (cnt >= GUARD_C);
    end
  endgenerate

  assign nib = sh_din[4*idx +: 4];
  assign lit = past_guard && sh_en[idx] && !sup[idx] && (pwm <= bright);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pwm        <= '0;
      sh_din     <= din;
      sh_dp      <= dp_in;
      sh_en      <= dig_en;
      an_out     <= '1;
      sev_out    <= 7'h7F;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      pwm        <= pwm + 4'd1;
      frame_tick <= 1'b0;
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        if (idx == IDX_MAX) begin
          // Frame end: new data becomes visible together with the tick.
          idx        <= '0;
          sh_din     <= din;
          sh_dp      <= dp_in;
          sh_en      <= dig_en;
          frame_tick <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (lit) begin
        an_out  <= ~(NUM_DIGITS'(1) << idx);
        sev_out <= decode(nib);
        dp_out  <= ~sh_dp[idx];
      end else begin
        an_out  <= '1;
        sev_out <= 7'h7F;
        dp_out  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_mux.sv
// Bench for sev_seg_mux (4 digits, 8-cycle slots, 2-cycle guard): every output cycle
// is predicted from the display rules and checked by a separate monitor.
module tb_sev_seg_mux;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FRAME = ND * RD;

  logic            clk = 1'b0;
  logic            rst;
  logic [4*ND-1:0] din;
  logic [ND-1:0]   dp_in;
  logic [ND-1:0]   dig_en;
  logic            lz_blank;
  logic [3:0]      bright;
  logic [6:0]      sev_out;
  logic            dp_out;
  logic [ND-1:0]   an_out;
  logic            frame_tick;

  sev_seg_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .dp_in      (dp_in),
    .dig_en     (dig_en),
    .lz_blank   (lz_blank),
    .bright     (bright),
    .sev_out    (sev_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  // clock
  always #5 clk = ~clk;

  // segment patterns {a..g}, active-low
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // scoreboard: {an_out, sev_out, dp_out, frame_tick}
  logic [12:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  // expected-state tracking
  int          m_t;
  logic [4*ND-1:0] m_din;
  logic [ND-1:0]   m_dp;
  logic [ND-1:0]   m_en;

  // driver: predicts the output produced by the coming edge, then waits for it
  task automatic tick(input string nm);
    logic [12:0] pend;
    logic [3:0]  nib;
    int          cnt_m, idx_m, pwm_m;
    logic        lit, sup, zr, ft;
    if (rst) begin
      pend  = {4'hF, 7'h7F, 1'b1, 1'b0};
      m_din = din;
      m_dp  = dp_in;
      m_en  = dig_en;
      m_t   = 0;
    end else begin
      cnt_m = m_t % RD;
      idx_m = (m_t / RD) % ND;
      pwm_m = m_t % 16;
      nib   = m_din[4*idx_m +: 4];
      zr    = 1'b1;
      for (int j = idx_m; j < ND; j++)
        if (m_din[4*j +: 4] != 4'h0) zr = 1'b0;
      sup = lz_blank && (idx_m != 0) && zr;
      lit = (cnt_m >= GD) && m_en[idx_m] && !sup && (pwm_m <= int'(bright));
      ft  = ((m_t % FRAME) == FRAME - 1);
      if (lit) pend = {~(4'b0001 << idx_m), seg_tab[nib], ~m_dp[idx_m], ft};
      else     pend = {4'hF, 7'h7F, 1'b1, ft};
      if (ft) begin
        m_din = din;
        m_dp  = dp_in;
        m_en  = dig_en;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(pend);
    name_q.push_back(nm);
  endtask

  // monitor
  initial begin
    logic [12:0] e;
    logic [12:0] g;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g  = {an_out, sev_out, dp_out, frame_tick};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s t=%0t: an/sev/dp/ft got %b/%b/%b/%b expected %b/%b/%b/%b",
                   nm, $time, g[12:9], g[8:2], g[1], g[0], e[12:9], e[8:2], e[1], e[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    int guard_cnt;
    rst      = 1'b1;
    din      = 16'h12A4;
    dp_in    = 4'b0000;
    dig_en   = 4'hF;
    lz_blank = 1'b0;
    bright   = 4'd15;
    m_t      = 0;

    repeat (3) tick("reset");
    rst = 1'b0;
    repeat (2 * FRAME) tick("basic_scan");

    // new data while digit 1 is lit stays hidden until the frame tick
    guard_cnt = 0;
    while ((m_t % FRAME) != RD + 4 && guard_cnt < FRAME) begin
      tick("align");
      guard_cnt++;
    end
    din = 16'hFFFF;
    repeat (2 * FRAME) tick("frame_sync");

    dig_en = 4'b1010;
    dp_in  = 4'b0101;
    din    = 16'hC3E9;
    repeat (2 * FRAME) tick("enable_dp");

    dig_en   = 4'hF;
    dp_in    = 4'b0000;
    din      = 16'h0050;
    lz_blank = 1'b1;
    repeat (2 * FRAME) tick("lz_on");
    lz_blank = 1'b0;
    repeat (FRAME) tick("lz_off");
    din      = 16'h0000;
    lz_blank = 1'b1;
    repeat (2 * FRAME) tick("lz_all_zero");
    lz_blank = 1'b0;

    din    = 16'h7D8B;
    bright = 4'd3;
    dp_in  = 4'b0001;
    repeat (2 * FRAME) tick("bright");
    bright = 4'd0;
    repeat (FRAME) tick("bright_min");

    bright = 4'd15;
    dp_in  = 4'b0000;
    din    = 16'h1234;
    repeat (FRAME) tick("pre_reset");
    guard_cnt = 0;
    while ((m_t % FRAME) != 2 * RD + 3 && guard_cnt < FRAME) begin
      tick("align_reset");
      guard_cnt++;
    end
    rst = 1'b1;
    tick("mid_reset");
    rst = 1'b0;
    repeat (FRAME + RD) tick("post_reset");

    // drain with a bounded wait
    guard_cnt = 0;
    while (exp_q.size() > 0 && guard_cnt < 10) begin
      @(negedge clk);
      #1;
      guard_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
